// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS main FSM and its datapath.
// The controller drives the datapath enables and selects; the datapath
// returns the IR fields, the ALU zero flag and the memory-ready handshake.
interface mips_multicycle_ctrl_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         op;
    logic [5:0]         funct;
    logic               zero;
    logic               memReady;
    logic               memRead;
    logic               memWrite;
    logic               iord;
    logic               irWrite;
    logic               regDst;
    logic               memtoReg;
    logic               regWrite;
    logic               aluSrcA;
    logic [1:0]         aluSrcB;
    logic [2:0]         aluControl;
    logic [1:0]         pcSrc;
    logic               pcEn;
    logic               illegalOp;
    logic               instrDone;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, funct, zero, memReady,
        output memRead, memWrite, iord, irWrite, regDst, memtoReg, regWrite,
               aluSrcA, aluSrcB, aluControl, pcSrc, pcEn, illegalOp,
               instrDone, state
    );

    modport slave (
        output op, funct, zero, memReady,
        input  memRead, memWrite, iord, irWrite, regDst, memtoReg, regWrite,
               aluSrcA, aluSrcB, aluControl, pcSrc, pcEn, illegalOp,
               instrDone, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core. Sequences the shared
// memory, IR, register file, ALU and PC for lw, sw, R-type, beq, addi
// and j. Memory accesses stall until the memory reports ready.
module mips_multicycle_ctrl #(
    parameter int                 STATE_W     = 4,
    parameter logic [STATE_W-1:0] RESET_STATE = 4'd0
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        RTEX   = 4'd6,
        RTWB   = 4'd7,
        BEQEX  = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JEX    = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     stateQ;
    state_t     stateD;

    logic       memRead;
    logic       memWrite;
    logic       iord;
    logic       irWrite;
    logic       regDst;
    logic       memtoReg;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluControl;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic       illegalOp;
    logic       instrDone;

    // State register; reset abandons any instruction in flight and refetches.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ <= state_t'(RESET_STATE[3:0]);
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state and output decode; memory states hold until memReady.
    always_comb begin
        stateD     = stateQ;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        iord       = 1'b0;
        irWrite    = 1'b0;
        regDst     = 1'b0;
        memtoReg   = 1'b0;
        regWrite   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        aluControl = 3'b000;
        pcSrc      = 2'b00;
        pcEn       = 1'b0;
        illegalOp  = 1'b0;
        instrDone  = 1'b0;

        case (stateQ)
            FETCH: begin
                memRead    = 1'b1;
                aluSrcB    = 2'b01;
                aluControl = ALU_ADD;
                if (bus.memReady) begin
                    irWrite = 1'b1;
                    pcEn    = 1'b1;
                    stateD  = DECODE;
                end
            end
            DECODE: begin
                aluSrcB    = 2'b11;
                aluControl = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: stateD = MEMADR;
                    OP_RTYPE:     stateD = RTEX;
                    OP_BEQ:       stateD = BEQEX;
                    OP_ADDI:      stateD = ADDIEX;
                    OP_J:         stateD = JEX;
                    default: begin
                        illegalOp = 1'b1;
                        stateD    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
                stateD     = (bus.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memRead = 1'b1;
                iord    = 1'b1;
                if (bus.memReady) begin
                    stateD = MEMWB;
                end
            end
            MEMWB: begin
                memtoReg  = 1'b1;
                regWrite  = 1'b1;
                instrDone = 1'b1;
                stateD    = FETCH;
            end
            MEMWR: begin
                memWrite = 1'b1;
                iord     = 1'b1;
                if (bus.memReady) begin
                    instrDone = 1'b1;
                    stateD    = FETCH;
                end
            end
            RTEX: begin
                aluSrcA = 1'b1;
                stateD  = RTWB;
                case (bus.funct)
                    6'b100000: aluControl = ALU_ADD;
                    6'b100010: aluControl = ALU_SUB;
                    6'b100100: aluControl = ALU_AND;
                    6'b100101: aluControl = ALU_OR;
                    6'b101010: aluControl = ALU_SLT;
                    default: begin
                        illegalOp = 1'b1;
                        stateD    = FETCH;
                    end
                endcase
            end
            RTWB: begin
                regDst    = 1'b1;
                regWrite  = 1'b1;
                instrDone = 1'b1;
                stateD    = FETCH;
            end
            BEQEX: begin
                aluSrcA    = 1'b1;
                aluControl = ALU_SUB;
                pcSrc      = 2'b01;
                pcEn       = bus.zero;
                instrDone  = 1'b1;
                stateD     = FETCH;
            end
            ADDIEX: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
                stateD     = ADDIWB;
            end
            ADDIWB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
                stateD    = FETCH;
            end
            JEX: begin
                pcSrc     = 2'b10;
                pcEn      = 1'b1;
                instrDone = 1'b1;
                stateD    = FETCH;
            end
            default: begin
                stateD = FETCH;
            end
        endcase
    end

    // Every output is held low while reset is asserted.
    assign bus.memRead    = reset & memRead;
    assign bus.memWrite   = reset & memWrite;
    assign bus.iord       = reset & iord;
    assign bus.irWrite    = reset & irWrite;
    assign bus.regDst     = reset & regDst;
    assign bus.memtoReg   = reset & memtoReg;
    assign bus.regWrite   = reset & regWrite;
    assign bus.aluSrcA    = reset & aluSrcA;
    assign bus.aluSrcB    = reset ? aluSrcB : 2'b00;
    assign bus.aluControl = reset ? aluControl : 3'b000;
    assign bus.pcSrc      = reset ? pcSrc : 2'b00;
    assign bus.pcEn       = reset & pcEn;
    assign bus.illegalOp  = reset & illegalOp;
    assign bus.instrDone  = reset & instrDone;
    assign bus.state      = STATE_W'(stateQ);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for the multicycle MIPS control FSM. The reference
// model is instruction-level: each fetched instruction expands to its
// list of state codes, and each output is a per-signal rule over the
// current code and the live inputs.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic reset;

    mips_multicycle_ctrl_if #(.STATE_W(4)) bus();

    mips_multicycle_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    int vectors     = 0;
    int miscompares = 0;

    int expState = 0;
    int path[$];
    logic [5:0] nextOp    = 6'd0;
    logic [5:0] nextFunct = 6'd0;

    logic [7:0] sState, sAluCtl, sPcSrc;
    logic       sMemRead, sMemWrite, sIrWrite, sRegWrite, sRegDst;
    logic       sMemtoReg, sPcEn, sIllegal, sDone;

    function automatic bit legalOp(input logic [5:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == BEQ) ||
               (o == ADDI) || (o == JMP);
    endfunction

    function automatic bit legalFunct(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    function automatic logic [2:0] functAlu(input logic [5:0] f);
        if (f == 6'b100000) return 3'b010;
        if (f == 6'b100010) return 3'b110;
        if (f == 6'b100100) return 3'b000;
        if (f == 6'b100101) return 3'b001;
        return 3'b111;
    endfunction

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output with the model for the current expected state.
    task automatic checkOutput();
        int   s;
        bit   rn, rdy, z;
        logic [7:0] eAluSrcB, eAluCtl, ePcSrc;
        s   = expState;
        rn  = reset;
        rdy = bus.memReady;
        z   = bus.zero;

        sState    = 8'(bus.state);
        sAluCtl   = 8'(bus.aluControl);
        sPcSrc    = 8'(bus.pcSrc);
        sMemRead  = bus.memRead;
        sMemWrite = bus.memWrite;
        sIrWrite  = bus.irWrite;
        sRegWrite = bus.regWrite;
        sRegDst   = bus.regDst;
        sMemtoReg = bus.memtoReg;
        sPcEn     = bus.pcEn;
        sIllegal  = bus.illegalOp;
        sDone     = bus.instrDone;

        eAluSrcB = !rn ? 8'd0 : (s == 0) ? 8'd1 : (s == 1) ? 8'd3 :
                   (s == 2 || s == 9) ? 8'd2 : 8'd0;
        eAluCtl  = !rn ? 8'd0 : (s <= 2 || s == 9) ? 8'd2 : (s == 8) ? 8'd6 :
                   (s == 6) ? 8'(functAlu(bus.funct)) : 8'd0;
        ePcSrc   = !rn ? 8'd0 : (s == 8) ? 8'd1 : (s == 11) ? 8'd2 : 8'd0;

        cmp("state",     sState, 8'(s));
        cmp("memRead",   8'(sMemRead),  8'(rn && (s == 0 || s == 3)));
        cmp("memWrite",  8'(sMemWrite), 8'(rn && s == 5));
        cmp("iord",      8'(bus.iord),  8'(rn && (s == 3 || s == 5)));
        cmp("irWrite",   8'(sIrWrite),  8'(rn && s == 0 && rdy));
        cmp("regDst",    8'(sRegDst),   8'(rn && s == 7));
        cmp("memtoReg",  8'(sMemtoReg), 8'(rn && s == 4));
        cmp("regWrite",  8'(sRegWrite), 8'(rn && (s == 4 || s == 7 || s == 10)));
        cmp("aluSrcA",   8'(bus.aluSrcA), 8'(rn && (s == 2 || s == 6 || s == 8 || s == 9)));
        cmp("aluSrcB",   8'(bus.aluSrcB), eAluSrcB);
        if (!(rn && s == 6 && !legalFunct(bus.funct)))
            cmp("aluControl", sAluCtl, eAluCtl);
        cmp("pcSrc",     sPcSrc, ePcSrc);
        cmp("pcEn",      8'(sPcEn), 8'(rn && ((s == 0 && rdy) || (s == 8 && z) || s == 11)));
        cmp("illegalOp", 8'(sIllegal), 8'(rn && ((s == 1 && !legalOp(bus.op)) ||
                                                (s == 6 && !legalFunct(bus.funct)))));
        cmp("instrDone", 8'(sDone), 8'(rn && ((s == 4 || s == 7 || s == 8 || s == 10 ||
                                             s == 11) || (s == 5 && rdy))));
        cmp("rdWrExcl",  8'(sMemRead & sMemWrite), 8'd0);
        cmp("regPcExcl", 8'(sRegWrite & sPcEn), 8'd0);
    endtask

    // One clock cycle: drive inputs, check at negedge, advance the model.
    task automatic applyStimulus(input bit rdy, input bit z, input bit rstN);
        bit fetchDone;
        bus.memReady = rdy;
        bus.zero     = z;
        reset        = rstN;
        @(negedge clk);
        checkOutput();
        fetchDone = 0;
        if (!rstN) begin
            expState = 0;
            path.delete();
        end else if ((expState == 0 || expState == 3 || expState == 5) && !rdy) begin
            expState = expState;
        end else begin
            if (expState == 0) begin
                fetchDone = 1;
                path.delete();
                path.push_back(1);
                case (nextOp)
                    LW:   begin path.push_back(2); path.push_back(3); path.push_back(4); end
                    SW:   begin path.push_back(2); path.push_back(5); end
                    RT:   begin
                              path.push_back(6);
                              if (legalFunct(nextFunct)) path.push_back(7);
                          end
                    BEQ:  path.push_back(8);
                    ADDI: begin path.push_back(9); path.push_back(10); end
                    JMP:  path.push_back(11);
                    default: ;
                endcase
            end
            expState = (path.size() > 0) ? path.pop_front() : 0;
        end
        @(posedge clk);
        #1;
        if (fetchDone) begin
            bus.op    = nextOp;
            bus.funct = nextFunct;
        end
    endtask

    // Fetch cycle with memory ready; the previous instruction must be over.
    task automatic fetch(input logic [5:0] o, input logic [5:0] f);
        nextOp    = o;
        nextFunct = f;
        applyStimulus(1'b1, 1'b0, 1'b1);
        cmp("pinFetchState", sState, 8'd0);
        cmp("pinFetchIr", 8'(sIrWrite), 8'd1);
    endtask

    // Directed scenarios with literal expectations, then randomized traffic.
    initial begin
        int lwStates[4] = '{1, 2, 3, 4};
        int cnt;
        int doneCnt;
        logic [5:0] r;

        reset        = 1'b0;
        bus.memReady = 1'b1;
        bus.zero     = 1'b0;
        bus.op       = 6'd0;
        bus.funct    = 6'd0;
        @(posedge clk);
        #1;
        expState = 0;

        nextOp = LW;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            cmp("pinRstMemRead", 8'(sMemRead), 8'd0);
            cmp("pinRstIrWrite", 8'(sIrWrite), 8'd0);
            cmp("pinRstPcEn", 8'(sPcEn), 8'd0);
        end
        fetch(LW, 6'd0);
        cmp("pinFirstMemRead", 8'(sMemRead), 8'd1);

        doneCnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            cmp("pinLwState", sState, 8'(lwStates[i]));
            cmp("pinLwRegWrite", 8'(sRegWrite & sMemtoReg), 8'(i == 3));
            doneCnt += int'(sDone);
        end
        cmp("pinLwDoneCount", 8'(doneCnt), 8'd1);

        fetch(RT, 6'b100010);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        cmp("pinSubState", sState, 8'd6);
        cmp("pinSubAlu", sAluCtl, 8'b110);
        applyStimulus(1'b1, 1'b0, 1'b1);
        cmp("pinRtwbWrite", 8'(sRegWrite & sRegDst), 8'd1);

        fetch(RT, 6'b101010);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        cmp("pinSltAlu", sAluCtl, 8'b111);
        applyStimulus(1'b1, 1'b0, 1'b1);
        cmp("pinSltDone", 8'(sDone), 8'd1);

        fetch(BEQ, 6'd0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        cmp("pinBeqTakenPcEn", 8'(sPcEn), 8'd1);
        cmp("pinBeqPcSrc", sPcSrc, 8'd1);

        fetch(BEQ, 6'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        cmp("pinBeqNotTakenPcEn", 8'(sPcEn), 8'd0);
        cmp("pinBeqNotTakenDone", 8'(sDone), 8'd1);

        fetch(SW, 6'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i == 3, 1'b0, 1'b1);
            cnt += int'(sMemWrite);
            cmp("pinSwDone", 8'(sDone), 8'(i == 3));
        end
        cmp("pinSwMemWriteCycles", 8'(cnt), 8'd4);

        fetch(6'b111111, 6'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        cmp("pinIllegalPulse", 8'(sIllegal), 8'd1);
        cmp("pinIllegalNoWrite", 8'(sRegWrite), 8'd0);

        fetch(LW, 6'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        cmp("pinMemrdState", sState, 8'd3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        cmp("pinRstMidRegWrite", 8'(sRegWrite), 8'd0);
        cmp("pinRstMidMemRead", 8'(sMemRead), 8'd0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        cmp("pinAfterRstState", sState, 8'd0);
        cmp("pinAfterRstRegWrite", 8'(sRegWrite), 8'd0);

        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 6))
                0: nextOp = LW;
                1: nextOp = SW;
                2: nextOp = RT;
                3: nextOp = BEQ;
                4: nextOp = ADDI;
                5: nextOp = JMP;
                default: begin
                    r = 6'($urandom);
                    while (legalOp(r)) r = 6'($urandom);
                    nextOp = r;
                end
            endcase
            case ($urandom_range(0, 5))
                0: nextFunct = 6'b100000;
                1: nextFunct = 6'b100010;
                2: nextFunct = 6'b100100;
                3: nextFunct = 6'b100101;
                4: nextFunct = 6'b101010;
                default: nextFunct = 6'($urandom);
            endcase
            applyStimulus($urandom_range(0, 9) < 7, 1'($urandom),
                          $urandom_range(0, 99) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
